// File: rtl/ucie_param_exchange_responder.sv
// UCIe parameter-exchange responder.
// Accepts one capability request word, negotiates it against the local caps
// (min width, min speed, AND of protocol masks), answers with an ACK word or
// an all-zero NAK word, and records the negotiated result on ACK.
// Build option: define UCIE_PARAM_RESP_TIMEOUT_EN to bound the time SEND
// waits for tx_ready (RESP_TIMEOUT cycles); otherwise SEND waits forever.
module ucie_param_exchange_responder #(
  parameter int unsigned RESP_TIMEOUT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  local_width_cap,
  input  logic [7:0]  local_speed_cap,
  input  logic [15:0] local_proto_cap,
  input  logic [31:0] rx_param,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_param,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  neg_width,
  output logic [7:0]  neg_speed,
  output logic [15:0] neg_proto,
  output logic        neg_valid,
  output logic        param_error,
  output logic [1:0]  error_code,
  output logic [2:0]  resp_state,
  output logic [7:0]  exchange_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REQ = 3'd1,
    EVAL     = 3'd2,
    SEND     = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [31:0] req_q;
  logic [7:0]  width_q, speed_q, width_d, speed_d;
  logic [15:0] proto_q, proto_d;
  logic        ack_q, ack_d;
  logic [7:0]  neg_width_q, neg_speed_q;
  logic [15:0] neg_proto_q;
  logic        neg_valid_q;
  logic        param_error_q;
  logic [1:0]  error_code_q;
  logic [7:0]  exchange_count_q;

  logic accept, eval, ack_hs, nak_hs, timeout_evt;
  logic send_cnt_expired;

  // Negotiation of the captured request against the local capabilities.
  assign width_d = (req_q[31:24] < local_width_cap) ? req_q[31:24] : local_width_cap;
  assign speed_d = (req_q[23:16] < local_speed_cap) ? req_q[23:16] : local_speed_cap;
  assign proto_d = req_q[15:0] & local_proto_cap;
  assign ack_d   = (width_d != 8'd0) && (speed_d != 8'd0) && (proto_d != 16'd0);

`ifdef UCIE_PARAM_RESP_TIMEOUT_EN
  logic [31:0] send_cnt_q;
  logic [32:0] send_cnt_inc;

  assign send_cnt_inc     = {1'b0, send_cnt_q} + 33'd1;
  assign send_cnt_expired = (send_cnt_inc >= {1'b0, RESP_TIMEOUT});

  // Count cycles spent in SEND; held at zero outside SEND so each entry restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                send_cnt_q <= '0;
    else if (state_q != SEND)  send_cnt_q <= '0;
    else                       send_cnt_q <= send_cnt_inc[31:0];
  end
`else
  assign send_cnt_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the one-cycle strobes that drive the datapath.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rx_ready    = 1'b0;
    accept      = 1'b0;
    eval        = 1'b0;
    ack_hs      = 1'b0;
    nak_hs      = 1'b0;
    timeout_evt = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = WAIT_REQ;
        WAIT_REQ,
        DONE: begin
          rx_ready = 1'b1;
          if (rx_valid) begin
            accept  = 1'b1;
            state_d = EVAL;
          end
        end
        EVAL: begin
          eval    = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          // A handshake on the expiry cycle still completes the exchange.
          if (tx_ready) begin
            ack_hs  = ack_q;
            nak_hs  = !ack_q;
            state_d = ack_q ? DONE : ERROR;
          end else if (send_cnt_expired) begin
            timeout_evt = 1'b1;
            state_d     = ERROR;
          end
        end
        ERROR:    state_d = ERROR;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Request capture, negotiated result, status and exchange counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q            <= '0;
      width_q          <= '0;
      speed_q          <= '0;
      proto_q          <= '0;
      ack_q            <= 1'b0;
      neg_width_q      <= '0;
      neg_speed_q      <= '0;
      neg_proto_q      <= '0;
      neg_valid_q      <= 1'b0;
      param_error_q    <= 1'b0;
      error_code_q     <= 2'b00;
      exchange_count_q <= '0;
    end else begin
      if (accept) begin
        req_q       <= rx_param;
        neg_valid_q <= 1'b0;
      end
      if (eval) begin
        width_q <= width_d;
        speed_q <= speed_d;
        proto_q <= proto_d;
        ack_q   <= ack_d;
      end
      if (ack_hs) begin
        neg_width_q <= width_q;
        neg_speed_q <= speed_q;
        neg_proto_q <= proto_q;
        neg_valid_q <= 1'b1;
        if (exchange_count_q != 8'hFF) exchange_count_q <= exchange_count_q + 8'd1;
      end
      if (nak_hs) begin
        param_error_q <= 1'b1;
        error_code_q  <= 2'b01;
      end
      if (timeout_evt) begin
        param_error_q <= 1'b1;
        error_code_q  <= 2'b10;
      end
      // Disable abandons the exchange but keeps the lifetime exchange count.
      if (!enable) begin
        neg_valid_q   <= 1'b0;
        param_error_q <= 1'b0;
        error_code_q  <= 2'b00;
      end
    end
  end

  // Response is decoded from the state so reset removes it without a clock edge.
  assign tx_valid       = (state_q == SEND);
  assign tx_param       = (tx_valid && ack_q) ? {width_q, speed_q, proto_q} : 32'h0;
  assign neg_width      = neg_width_q;
  assign neg_speed      = neg_speed_q;
  assign neg_proto      = neg_proto_q;
  assign neg_valid      = neg_valid_q;
  assign param_error    = param_error_q;
  assign error_code     = error_code_q;
  assign resp_state     = state_q;
  assign exchange_count = exchange_count_q;

endmodule
